nx_stream_arbiter: RTL and testbench

- Shares one nx_node outbound stream port (e.g. ob_north) between SOURCES requesters: the four inbound-direction bypass streams (N/E/S/W) and the node's locally emitted messages.
- Uses round-robin arbitration and a single registered output stage.
- Discards traffic when no neighbour is present on that edge (present low).
- Reports idle, which feeds into the node's idle_o aggregation.

---
 rtl/nx_pkg.sv | 14 +
 rtl/nx_rr_picker.sv | 37 +++
 rtl/nx_stream_arbiter.sv | 89 ++++++++
 tb/tb_nx_stream_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/nx_pkg.sv
// Shared node-level types and constants for the nx_node stream blocks.
package nx_pkg;

  localparam int NX_DIRECTIONS = 4;

  typedef enum logic [2:0] {
    NX_DIR_NORTH = 3'd0,
    NX_DIR_EAST,
    NX_DIR_SOUTH,
    NX_DIR_WEST,
    NX_DIR_LOCAL
  } nx_direction_t;

endpackage

// File: rtl/nx_rr_picker.sv
// Combinational rotating-priority picker: first set request at or after ptr,
// wrapping modulo N. Returns one-hot grant, its index and an any-request flag.
module nx_rr_picker
  import nx_pkg::*;
#(
  parameter int N = 5,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt,
  output logic [W-1:0] idx,
  output logic         any
);

  int unsigned j;
  logic [W-1:0] jj;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    jj  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr) + i;
      if (j >= N) j = j - N;
      jj = W'(j);
      if (!any && req[jj]) begin
        any     = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/nx_stream_arbiter.sv
// Round-robin arbiter sharing one outbound stream among SOURCES requesters,
// with a single registered output stage. Optional: NX_ARB_DROP_COUNT_EN.
module nx_stream_arbiter
  import nx_pkg::*;
#(
  parameter int STREAM_WIDTH = 32,
  parameter int SOURCES      = 5,
  parameter int SRC_W        = $clog2(SOURCES)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [SOURCES*STREAM_WIDTH-1:0] in_data_i,
  input  logic [SOURCES-1:0]            in_valid_i,
  output logic [SOURCES-1:0]            in_ready_o,
  output logic [STREAM_WIDTH-1:0]       out_data_o,
  output logic                          out_valid_o,
  input  logic                          out_ready_i,
  input  logic                          out_present_i,
  output logic [SRC_W-1:0]              grant_o,
  output logic                          idle_o
`ifdef NX_ARB_DROP_COUNT_EN
  ,
  output logic [15:0]                   drop_count_o
`endif
);

  logic [SRC_W-1:0]        rr_ptr;
  logic [SRC_W-1:0]        rr_next;
  logic [SOURCES-1:0]      pick_gnt;
  logic [SRC_W-1:0]        pick;
  logic                    pick_any;
  logic                    can_load;
  logic                    accept;
  logic [STREAM_WIDTH-1:0] pick_data;

  nx_rr_picker #(
    .N (SOURCES),
    .W (SRC_W)
  ) u_picker (
    .req (in_valid_i),
    .ptr (rr_ptr),
    .gnt (pick_gnt),
    .idx (pick),
    .any (pick_any)
  );

  // An absent neighbour turns the port into a sink, so it can always load.
  assign can_load   = !out_present_i || !out_valid_o || out_ready_i;
  assign accept     = rst_i && can_load && pick_any;
  assign in_ready_o = accept ? pick_gnt : '0;
  assign pick_data  = in_data_i[32'(pick)*STREAM_WIDTH +: STREAM_WIDTH];
  assign rr_next    = (32'(pick) == SOURCES - 1) ? '0 : pick + SRC_W'(1);
  assign idle_o     = !(|in_valid_i) && !out_valid_o;

`ifdef NX_ARB_DROP_COUNT_EN
  logic [1:0]  drops;
  logic [16:0] drop_sum;

  assign drops    = 2'(accept && !out_present_i) + 2'(out_valid_o && !out_present_i);
  assign drop_sum = {1'b0, drop_count_o} + 17'(drops);
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      grant_o     <= '0;
      rr_ptr      <= '0;
`ifdef NX_ARB_DROP_COUNT_EN
      drop_count_o <= '0;
`endif
    end else begin
      if (accept) rr_ptr <= rr_next;
      if (!out_present_i) begin
        out_valid_o <= 1'b0;
      end else if (accept) begin
        out_valid_o <= 1'b1;
        out_data_o  <= pick_data;
        grant_o     <= pick;
      end else if (out_ready_i) begin
        out_valid_o <= 1'b0;
      end
`ifdef NX_ARB_DROP_COUNT_EN
      drop_count_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
`endif
    end
  end

endmodule

// File: tb/tb_nx_stream_arbiter.sv
// Directed, table-driven bench for nx_stream_arbiter (default parameters).
module tb_nx_stream_arbiter;

  localparam int SW = 32;
  localparam int NS = 5;
  localparam int GW = 3;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NS*SW-1:0]     in_data_i;
  logic [NS-1:0]        in_valid_i;
  logic [NS-1:0]        in_ready_o;
  logic [SW-1:0]        out_data_o;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic                 out_present_i;
  logic [GW-1:0]        grant_o;
  logic                 idle_o;
`ifdef NX_ARB_DROP_COUNT_EN
  logic [15:0]          drop_count_o;
`endif

  logic [SW-1:0] data_src [NS];

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  always_comb begin
    in_data_i = '0;
    for (int s = 0; s < NS; s++) in_data_i[s*SW +: SW] = data_src[s];
  end

  nx_stream_arbiter #(
    .STREAM_WIDTH (SW),
    .SOURCES      (NS)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_data_i     (in_data_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .out_data_o    (out_data_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_present_i (out_present_i),
    .grant_o       (grant_o),
    .idle_o        (idle_o)
`ifdef NX_ARB_DROP_COUNT_EN
    ,
    .drop_count_o  (drop_count_o)
`endif
  );

  typedef struct {
    logic          rst;
    logic [NS-1:0] valid;
    logic          rdy;
    logic          pres;
    logic [NS-1:0] exp_inr;
    logic          exp_ov;
    logic          chk_od;
    logic [SW-1:0] exp_od;
    logic [GW-1:0] exp_gr;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [NS-1:0] valid, logic rdy, logic pres,
                              logic [NS-1:0] exp_inr, logic exp_ov, logic chk_od,
                              logic [SW-1:0] exp_od, logic [GW-1:0] exp_gr);
    vec_t v;
    v.rst = rst; v.valid = valid; v.rdy = rdy; v.pres = pres;
    v.exp_inr = exp_inr; v.exp_ov = exp_ov; v.chk_od = chk_od;
    v.exp_od = exp_od; v.exp_gr = exp_gr;
    return v;
  endfunction

  task automatic check(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d got=%h want=%h", nm, id, act, exp);
    end
  endtask

  // Drive after the rising edge, sample on the falling edge.
  task automatic step(input vec_t v, input int id);
    logic exp_idle;
    @(posedge clk_i);
    #1;
    rst_i         = v.rst;
    in_valid_i    = v.valid;
    out_ready_i   = v.rdy;
    out_present_i = v.pres;
    @(negedge clk_i);
    exp_idle = !(|v.valid) && !v.exp_ov;
    check("in_ready", id, 32'(in_ready_o), 32'(v.exp_inr));
    check("out_valid", id, 32'(out_valid_o), 32'(v.exp_ov));
    check("idle", id, 32'(idle_o), 32'(exp_idle));
    if (v.chk_od) begin
      check("out_data", id, out_data_o, v.exp_od);
      check("grant", id, 32'(grant_o), 32'(v.exp_gr));
    end
  endtask

  task automatic check_drops(input int id, input int exp);
`ifdef NX_ARB_DROP_COUNT_EN
    check("drop_count", id, 32'(drop_count_o), 32'(exp));
`else
    if (id < 0 || exp < 0) $display("unexpected drop check arguments");
`endif
  endtask

  task automatic default_data();
    for (int s = 0; s < NS; s++) data_src[s] = 32'h10 + 32'(s);
  endtask

  vec_t tbl [14];

  initial begin
    rst_i         = 1'b0;
    in_valid_i    = '1;
    out_ready_i   = 1'b1;
    out_present_i = 1'b1;
    default_data();

    // Round-robin over all five sources, then sparse 4/1 wrap from rr_ptr=2.
    tbl[0]  = mk(1, 5'b11111, 1, 1, 5'b00001, 0, 1, 32'h00, 0);
    tbl[1]  = mk(1, 5'b11111, 1, 1, 5'b00010, 1, 1, 32'h10, 0);
    tbl[2]  = mk(1, 5'b11111, 1, 1, 5'b00100, 1, 1, 32'h11, 1);
    tbl[3]  = mk(1, 5'b11111, 1, 1, 5'b01000, 1, 1, 32'h12, 2);
    tbl[4]  = mk(1, 5'b11111, 1, 1, 5'b10000, 1, 1, 32'h13, 3);
    tbl[5]  = mk(1, 5'b11111, 1, 1, 5'b00001, 1, 1, 32'h14, 4);
    tbl[6]  = mk(1, 5'b00000, 1, 1, 5'b00000, 1, 1, 32'h10, 0);
    tbl[7]  = mk(1, 5'b00000, 1, 1, 5'b00000, 0, 1, 32'h10, 0);
    tbl[8]  = mk(1, 5'b00010, 1, 1, 5'b00010, 0, 0, 32'h00, 0);
    tbl[9]  = mk(1, 5'b10010, 1, 1, 5'b10000, 1, 1, 32'h11, 1);
    tbl[10] = mk(1, 5'b10010, 1, 1, 5'b00010, 1, 1, 32'h14, 4);
    tbl[11] = mk(1, 5'b10010, 1, 1, 5'b10000, 1, 1, 32'h11, 1);
    tbl[12] = mk(1, 5'b10010, 1, 1, 5'b00010, 1, 1, 32'h14, 4);
    tbl[13] = mk(1, 5'b00000, 1, 1, 5'b00000, 1, 1, 32'h11, 1);

    // Reset held three cycles with every source requesting.
    for (int i = 0; i < 3; i++)
      step(mk(0, 5'b11111, 1, 1, 5'b00000, 0, 1, 32'h0, 0), 100 + i);
    check_drops(103, 0);

    for (int i = 0; i < 14; i++) step(tbl[i], i);

    // Backpressure holding 0xA5A5A5A5, then load without a bubble.
    data_src[3] = 32'hA5A5A5A5;
    data_src[0] = 32'h5A5A5A5A;
    step(mk(1, 5'b01000, 0, 1, 5'b01000, 0, 1, 32'h11, 1), 200);
    for (int i = 0; i < 4; i++)
      step(mk(1, 5'b00001, 0, 1, 5'b00000, 1, 1, 32'hA5A5A5A5, 3), 201 + i);
    step(mk(1, 5'b00001, 1, 1, 5'b00001, 1, 1, 32'hA5A5A5A5, 3), 205);
    step(mk(1, 5'b00000, 0, 1, 5'b00000, 1, 1, 32'h5A5A5A5A, 0), 206);
    step(mk(1, 5'b00000, 1, 1, 5'b00000, 1, 1, 32'h5A5A5A5A, 0), 207);
    default_data();

    // Absent neighbour: three sink handshakes from source 2.
    for (int i = 0; i < 3; i++)
      step(mk(1, 5'b00100, 0, 0, 5'b00100, 0, 0, 32'h0, 0), 300 + i);
    step(mk(1, 5'b00000, 0, 0, 5'b00000, 0, 0, 32'h0, 0), 303);
    check_drops(303, 3);

    // Present falls while a word is held under backpressure.
    step(mk(1, 5'b10000, 0, 1, 5'b10000, 0, 0, 32'h0, 0), 400);
    step(mk(1, 5'b00000, 0, 1, 5'b00000, 1, 1, 32'h14, 4), 401);
    step(mk(1, 5'b00000, 0, 0, 5'b00000, 1, 1, 32'h14, 4), 402);
    step(mk(1, 5'b00000, 0, 1, 5'b00000, 0, 0, 32'h0, 0), 403);
    check_drops(403, 4);

    // Reset while a word is held.
    step(mk(1, 5'b00001, 0, 1, 5'b00001, 0, 0, 32'h0, 0), 500);
    step(mk(1, 5'b00000, 0, 1, 5'b00000, 1, 1, 32'h10, 0), 501);
    step(mk(0, 5'b00010, 0, 1, 5'b00000, 1, 1, 32'h10, 0), 502);
    step(mk(1, 5'b00000, 0, 1, 5'b00000, 0, 1, 32'h0, 0), 503);
    check_drops(503, 0);
    step(mk(1, 5'b11111, 1, 1, 5'b00001, 0, 1, 32'h0, 0), 504);
    step(mk(1, 5'b00000, 1, 1, 5'b00000, 1, 1, 32'h10, 0), 505);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
